// File: rtl/disp_pkg.sv
// Shared display constants: default scanner geometry, strobe polarity and a
// width helper used for index and counter sizing.
package disp_pkg;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_DIV          = 100000;
    localparam int DEF_BLANK_CYCLES = 1000;

    // Level driven onto the selected digit strobe; all other strobes get the inverse.
    localparam logic SEL_ON = 1'b1;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_scanner_tick_gen.sv
// Slot prescaler for the digit scanner: counts enabled cycles 0..DIV-1 and flags
// the enabled cycle that closes a slot.
module tick_gen
    import disp_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap
);

    localparam int            CW   = idx_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Combinational so the scanner can move idx, sel and tick on the same edge.
    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// Multiplexed display digit scanner: one-hot strobe, digit index and change tick.
// Optional start-of-slot blanking is built only when DIGIT_SCANNER_BLANK_EN is defined.
module digit_scanner
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DIV          = DEF_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic [NUM_DIGITS-1:0]        sel,
    output logic [idx_w(NUM_DIGITS)-1:0] idx,
    output logic                         tick
);

    localparam int IW = idx_w(NUM_DIGITS);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("digit_scanner: NUM_DIGITS=%0d outside 1..16", NUM_DIGITS);
    end
    if (DIV < 1 || DIV > (1 << 24)) begin : g_bad_div
        $error("digit_scanner: DIV=%0d outside 1..2^24", DIV);
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES > DIV - 1) begin : g_bad_blank
        $error("digit_scanner: BLANK_CYCLES=%0d outside 0..DIV-1", BLANK_CYCLES);
    end

    localparam logic [NUM_DIGITS-1:0] SEL_MSB =
        {SEL_ON, {(NUM_DIGITS - 1){~SEL_ON}}};

    logic          wrap;
    logic [IW-1:0] idx_nxt;
    logic [NUM_DIGITS-1:0] sel_nxt;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .wrap (wrap)
    );

`ifdef DIGIT_SCANNER_BLANK_EN
    localparam int BW = idx_w(BLANK_CYCLES + 1);
    localparam logic [NUM_DIGITS-1:0] SEL_RST = (BLANK_CYCLES > 0) ? '0 : SEL_MSB;

    // Tracks min(prescaler, BLANK_CYCLES) so blanking follows the prescaler
    // without widening the tick_gen interface.
    logic [BW-1:0] blk_cnt, blk_nxt;

    always_comb begin
        blk_nxt = blk_cnt;
        if (wrap) begin
            blk_nxt = '0;
        end else if (en && blk_cnt < BW'(BLANK_CYCLES)) begin
            blk_nxt = blk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
        end else begin
            blk_cnt <= blk_nxt;
        end
    end
`else
    localparam logic [NUM_DIGITS-1:0] SEL_RST = SEL_MSB;
`endif

    always_comb begin
        idx_nxt = idx;
        if (wrap) begin
            idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
        // Digit 0 sits on the MSB strobe.
        sel_nxt = {NUM_DIGITS{~SEL_ON}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(NUM_DIGITS - 1 - i)) begin
                sel_nxt[i] = SEL_ON;
            end
        end
`ifdef DIGIT_SCANNER_BLANK_EN
        if (blk_nxt < BW'(BLANK_CYCLES)) begin
            sel_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            sel  <= SEL_RST;
            tick <= 1'b0;
        end else begin
            idx  <= idx_nxt;
            sel  <= sel_nxt;
            tick <= wrap;
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner: four parameterisations on shared stimulus, checked
// against a model driven only by the count of enabled cycles since reset.
module tb_digit_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] sel_a, sel_b, sel_d;
    logic [1:0] idx_a, idx_b, idx_d;
    logic       sel_c, idx_c;
    logic       tick_a, tick_b, tick_c, tick_d;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: enabled cycles since reset, and whether the last edge counted.
    int ev  = 0;
    bit adv = 1'b0;

`ifdef DIGIT_SCANNER_BLANK_EN
    localparam int BLK_D = 1;
`else
    localparam int BLK_D = 0;
`endif

    digit_scanner #(.NUM_DIGITS(4), .DIV(3), .BLANK_CYCLES(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .sel(sel_a), .idx(idx_a), .tick(tick_a));
    digit_scanner #(.NUM_DIGITS(4), .DIV(1), .BLANK_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .sel(sel_b), .idx(idx_b), .tick(tick_b));
    digit_scanner #(.NUM_DIGITS(1), .DIV(3), .BLANK_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .sel(sel_c), .idx(idx_c), .tick(tick_c));
    digit_scanner #(.NUM_DIGITS(4), .DIV(4), .BLANK_CYCLES(1)) u_d (
        .clk(clk), .rst(rst), .en(en), .sel(sel_d), .idx(idx_d), .tick(tick_d));

    logic [3:0] exp_tab [4];
    initial exp_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    function automatic logic [3:0] m_sel4(input int div, input int blk);
        if ((ev % div) < blk) return 4'b0000;
        return 4'b1000 >> ((ev / div) % 4);
    endfunction

    function automatic logic [1:0] m_idx4(input int div);
        return 2'((ev / div) % 4);
    endfunction

    function automatic logic m_tick(input int div);
        return adv && ((ev % div) == 0);
    endfunction

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            ev = 0; adv = 1'b0;
        end else if (e) begin
            ev = ev + 1; adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step(1'b1, 1'b1);
        n_tests++; if ({sel_a, idx_a, tick_a} !== 7'b1000_00_0) begin
            n_fail++; $display("FAIL reset_a got %b exp %b", {sel_a, idx_a, tick_a}, 7'b1000_00_0); end
        n_tests++; if ({sel_b, idx_b, tick_b} !== 7'b1000_00_0) begin
            n_fail++; $display("FAIL reset_b got %b exp %b", {sel_b, idx_b, tick_b}, 7'b1000_00_0); end
        n_tests++; if ({sel_c, idx_c, tick_c} !== 3'b1_0_0) begin
            n_fail++; $display("FAIL reset_c got %b exp %b", {sel_c, idx_c, tick_c}, 3'b1_0_0); end
        n_tests++; if (sel_d !== ((BLK_D > 0) ? 4'b0000 : 4'b1000)) begin
            n_fail++; $display("FAIL reset_d_sel got %b exp %b", sel_d, (BLK_D > 0) ? 4'b0000 : 4'b1000); end
    endtask

    task automatic test_scan_order();
        step(1'b1, 1'b0);
        for (int c = 0; c < 15; c++) begin
            n_tests++; if (sel_a !== exp_tab[(c / 3) % 4] || tick_a !== (c == 3 || c == 6 || c == 9 || c == 12)) begin
                n_fail++; $display("FAIL scan_a c=%0d got sel=%b tick=%b exp sel=%b tick=%b", c, sel_a, tick_a,
                                   exp_tab[(c / 3) % 4], (c == 3 || c == 6 || c == 9 || c == 12)); end
            n_tests++; if (sel_b !== exp_tab[c % 4] || tick_b !== (c > 0)) begin
                n_fail++; $display("FAIL scan_div1 c=%0d got sel=%b tick=%b exp sel=%b tick=%b", c, sel_b, tick_b,
                                   exp_tab[c % 4], (c > 0)); end
            n_tests++; if (sel_c !== 1'b1 || idx_c !== 1'b0 || tick_c !== (c > 0 && c % 3 == 0)) begin
                n_fail++; $display("FAIL scan_one c=%0d got sel=%b idx=%b tick=%b exp 1 0 %b", c, sel_c, idx_c, tick_c,
                                   (c > 0 && c % 3 == 0)); end
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_enable_hold();
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b1);
        n_tests++; if (idx_a !== 2'd2) begin
            n_fail++; $display("FAIL hold_setup got idx=%0d exp 2", idx_a); end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0);
            n_tests++; if (sel_a !== 4'b0010 || tick_a !== 1'b0 || tick_b !== 1'b0) begin
                n_fail++; $display("FAIL hold_frozen k=%0d got sel=%b tick=%b/%b exp 0010 0/0", k, sel_a, tick_a, tick_b); end
        end
        step(1'b0, 1'b1);
        n_tests++; if (idx_a !== 2'd2 || tick_a !== 1'b0) begin
            n_fail++; $display("FAIL hold_resume1 got idx=%0d tick=%b exp 2 0", idx_a, tick_a); end
        step(1'b0, 1'b1);
        n_tests++; if (idx_a !== 2'd3 || sel_a !== 4'b0001 || tick_a !== 1'b1) begin
            n_fail++; $display("FAIL hold_resume2 got idx=%0d sel=%b tick=%b exp 3 0001 1", idx_a, sel_a, tick_a); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b1);
        n_tests++; if (idx_a !== 2'd3) begin
            n_fail++; $display("FAIL rstmid_setup got idx=%0d exp 3", idx_a); end
        step(1'b1, 1'b1);
        n_tests++; if ({sel_a, idx_a, tick_a} !== 7'b1000_00_0) begin
            n_fail++; $display("FAIL rstmid_clear got %b exp %b", {sel_a, idx_a, tick_a}, 7'b1000_00_0); end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1);
            n_tests++; if (idx_a !== ((k == 3) ? 2'd1 : 2'd0) || tick_a !== (k == 3)) begin
                n_fail++; $display("FAIL rstmid_slot k=%0d got idx=%0d tick=%b exp %0d %b", k, idx_a, tick_a,
                                   (k == 3) ? 1 : 0, (k == 3)); end
        end
    endtask

    task automatic test_blank();
        step(1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            n_tests++; if (sel_d !== (((c % 4) < BLK_D) ? 4'b0000 : exp_tab[(c / 4) % 4])) begin
                n_fail++; $display("FAIL blank c=%0d got %b exp %b", c, sel_d,
                                   ((c % 4) < BLK_D) ? 4'b0000 : exp_tab[(c / 4) % 4]); end
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 50) == 0, ($urandom % 10) < 7);
            n_tests++; if (sel_a !== m_sel4(3, 0) || idx_a !== m_idx4(3) || tick_a !== m_tick(3)) begin
                n_fail++; $display("FAIL rand_a i=%0d got %b %0d %b exp %b %0d %b", i, sel_a, idx_a, tick_a,
                                   m_sel4(3, 0), m_idx4(3), m_tick(3)); end
            n_tests++; if (sel_b !== m_sel4(1, 0) || idx_b !== m_idx4(1) || tick_b !== m_tick(1)) begin
                n_fail++; $display("FAIL rand_b i=%0d got %b %0d %b exp %b %0d %b", i, sel_b, idx_b, tick_b,
                                   m_sel4(1, 0), m_idx4(1), m_tick(1)); end
            n_tests++; if (sel_c !== 1'b1 || idx_c !== 1'b0 || tick_c !== m_tick(3)) begin
                n_fail++; $display("FAIL rand_c i=%0d got %b %b %b exp 1 0 %b", i, sel_c, idx_c, tick_c, m_tick(3)); end
            n_tests++; if (sel_d !== m_sel4(4, BLK_D) || idx_d !== m_idx4(4) || tick_d !== m_tick(4)) begin
                n_fail++; $display("FAIL rand_d i=%0d got %b %0d %b exp %b %0d %b", i, sel_d, idx_d, tick_d,
                                   m_sel4(4, BLK_D), m_idx4(4), m_tick(4)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_enable_hold();
        test_reset_mid();
        test_blank();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
